// File: rtl/mem_port_arbiter_r0_if.sv
// Handshake bundle between the IF/DM requesters, the shared memory port and the arbiter.
// The arbiter uses the slave view; the requester/memory side uses the master view.
interface mem_port_arbiter_r0_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    logic              dm_req;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [3:0]        dm_we;
    logic [3:0]        dm_re;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_we;
    logic [3:0]        mem_re;
    logic [DATA_W-1:0] mem_rdata;
    logic              stall;

    modport master (
        output if_req, if_addr, dm_req, dm_addr, dm_wdata, dm_we, dm_re, mem_rdata,
        input  if_rdata, if_ready, dm_rdata, dm_ready, mem_addr, mem_wdata, mem_we, mem_re, stall
    );

    modport slave (
        input  if_req, if_addr, dm_req, dm_addr, dm_wdata, dm_we, dm_re, mem_rdata,
        output if_rdata, if_ready, dm_rdata, dm_ready, mem_addr, mem_wdata, mem_we, mem_re, stall
    );
endinterface

// File: rtl/mem_port_arbiter_r0.sv
// Shares one fixed-latency memory port between instruction fetch and data memory,
// one transaction at a time, data-memory side having priority.
module mem_port_arbiter_r0 #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 2
) (
    input logic                  clk,
    input logic                  rst,
    mem_port_arbiter_r0_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              grant_dm_q, grant_dm_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        we_q, we_d;
    logic [3:0]        re_q, re_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        grant_dm_d = grant_dm_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        re_d       = re_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        case (state_q)
            IDLE: begin
                if (bus.dm_req) begin
                    grant_dm_d = 1'b1;
                    addr_d     = bus.dm_addr;
                    wdata_d    = bus.dm_wdata;
                    we_d       = bus.dm_we;
                    // a write suppresses any simultaneous read strobe
                    re_d       = (|bus.dm_we) ? '0 : bus.dm_re;
                    state_d    = ISSUE;
                end else if (bus.if_req) begin
                    grant_dm_d = 1'b0;
                    addr_d     = bus.if_addr;
                    wdata_d    = '0;
                    we_d       = '0;
                    re_d       = '1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = CNT_LOAD;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    if (!grant_dm_q) begin
                        if_rdata_d = bus.mem_rdata;
                    end else if (we_q == '0) begin
                        dm_rdata_d = bus.mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            grant_dm_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= '0;
            re_q       <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            grant_dm_q <= grant_dm_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            re_q       <= re_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    assign bus.mem_addr  = addr_q & ~ADDR_W'(3);
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_we    = (state_q == ISSUE) ? we_q : '0;
    assign bus.mem_re    = (state_q == ISSUE) ? re_q : '0;
    assign bus.if_ready  = (state_q == RESP) && !grant_dm_q;
    assign bus.dm_ready  = (state_q == RESP) && grant_dm_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.stall     = (bus.if_req & ~bus.if_ready) | (bus.dm_req & ~bus.dm_ready);
endmodule
